// File: rtl/i2c_write_sequencer.sv
// Register-write sequencer feeding the I2C byte controller: START, {DevAddr,W}, RegAddr, WrData, STOP.
// Optional watchdog on the controller's Completed pulse is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_write_sequencer #(
  parameter int STOP_SETTLE = 4
`ifdef I2C_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 512
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_completed,
  output logic [1:0] o_op,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ADDR   = 3'd2,
    S_REG    = 3'd3,
    S_DATA   = 3'd4,
    S_STOP   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] OP_STOP     = 2'd0;
  localparam logic [1:0] OP_START    = 2'd1;
  localparam logic [1:0] OP_CONTINUE = 2'd2;

  localparam int SW = (STOP_SETTLE > 1) ? $clog2(STOP_SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(STOP_SETTLE - 1);

  state_t          r_state;
  logic [1:0]      r_op;
  logic [7:0]      r_data;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_reg_addr;
  logic [7:0]      r_wr_data;
  logic [SW-1:0]   r_settle;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0]   r_wdog;
  logic            r_error;
  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

  // Handshake: a byte is launched when Data changes and is finished by a one-cycle
  // i_completed pulse; the next Op/Data are registered on that same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_STOP;
      r_data     <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_reg_addr <= 8'h00;
      r_wr_data  <= 8'h00;
      r_settle   <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_wdog     <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_reg_addr <= i_reg_addr;
            r_wr_data  <= i_wr_data;
            r_op       <= OP_START;
            r_data     <= {i_dev_addr, 1'b0};
            r_busy     <= 1'b1;
            r_state    <= S_LAUNCH;
`ifdef I2C_SEQ_TIMEOUT_EN
            r_error    <= 1'b0;
`endif
          end
        end
        S_LAUNCH: begin
          r_op    <= OP_CONTINUE;
          r_state <= S_ADDR;
`ifdef I2C_SEQ_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        S_ADDR, S_REG, S_DATA: begin
          if (i_completed) begin
`ifdef I2C_SEQ_TIMEOUT_EN
            r_wdog <= '0;
`endif
            case (r_state)
              S_ADDR: begin
                r_data  <= r_reg_addr;
                r_state <= S_REG;
              end
              S_REG: begin
                r_data  <= r_wr_data;
                r_state <= S_DATA;
              end
              default: begin
                r_op     <= OP_STOP;
                r_data   <= 8'h00;
                r_settle <= SETTLE_LOAD;
                r_state  <= S_STOP;
              end
            endcase
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (r_wdog == WD_LAST) begin
            r_error  <= 1'b1;
            r_op     <= OP_STOP;
            r_data   <= 8'h00;
            r_settle <= SETTLE_LOAD;
            r_state  <= S_STOP;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
`endif
        end
        // Op must stay STOP here so the controller's STOP_2 phase does not see RESTART.
        S_STOP: begin
          if (r_settle == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_op    = r_op;
  assign o_data  = r_data;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Randomized bench for i2c_write_sequencer: a byte-queue reference model paces Completed pulses
// and checks Op/Data/Busy/Done around every byte, the settle window, reset and ignored Starts.
module tb_i2c_write_sequencer;

  localparam int STOP_SETTLE = 4;
  localparam logic [1:0] OP_STOP = 2'd0, OP_START = 2'd1, OP_CONTINUE = 2'd2;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [6:0] i_dev_addr;
  logic [7:0] i_reg_addr;
  logic [7:0] i_wr_data;
  logic       i_completed;
  logic [1:0] o_op;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  i2c_write_sequencer #(.STOP_SETTLE(STOP_SETTLE)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_dev_addr(i_dev_addr),
    .i_reg_addr(i_reg_addr), .i_wr_data(i_wr_data), .i_completed(i_completed),
    .o_op(o_op), .o_data(o_data), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_state(o_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full write; the controller is modelled as a random byte time followed by a Completed pulse.
  task automatic run_txn(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd,
                         input bit mid_start, input bit start_in_done);
    logic [7:0] cur;
    int d;
    exp_q = {};
    exp_q.push_back({dev, 1'b0});
    exp_q.push_back(ra);
    exp_q.push_back(wd);
    i_dev_addr = dev;
    i_reg_addr = ra;
    i_wr_data  = wd;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("op_start", o_op, OP_START);
    check("data_devaddr", o_data, exp_q[0]);
    check("busy_launch", o_busy, 1'b1);
    @(negedge clk);
    check("op_continue_after_start", o_op, OP_CONTINUE);
    for (int b = 0; b < 3; b++) begin
      cur = exp_q.pop_front();
      d = $urandom_range(1, 12);
      for (int k = 0; k < d; k++) begin
        check("data_hold", o_data, cur);
        check("busy_byte", o_busy, 1'b1);
        if (mid_start && b == 1 && k == 0) begin
          i_start    = 1'b1;
          i_dev_addr = ~dev;
          i_reg_addr = ~ra;
          i_wr_data  = ~wd;
        end else begin
          i_start = 1'b0;
        end
        @(negedge clk);
      end
      i_start     = 1'b0;
      i_completed = 1'b1;
      @(negedge clk);
      i_completed = 1'b0;
      if (exp_q.size() > 0) begin
        check("op_ack2_continue", o_op, OP_CONTINUE);
        check("data_next", o_data, exp_q[0]);
      end else begin
        check("op_ack2_stop", o_op, OP_STOP);
        check("data_cleared", o_data, 8'h00);
      end
    end
    for (int k = 0; k < STOP_SETTLE; k++) begin
      check("op_stop2", o_op, OP_STOP);
      check("done_early", o_done, 1'b0);
      @(negedge clk);
    end
    check("done_pulse", o_done, 1'b1);
    check("busy_at_done", o_busy, 1'b1);
    if (start_in_done) begin
      i_start    = 1'b1;
      i_dev_addr = 7'($urandom);
      i_reg_addr = 8'($urandom);
      i_wr_data  = 8'($urandom);
    end
    @(negedge clk);
    i_start = 1'b0;
    check("done_single", o_done, 1'b0);
    check("busy_after_done", o_busy, 1'b0);
    check("op_idle", o_op, OP_STOP);
    check("error_zero", o_error, 1'b0);
  endtask

  task automatic reset_mid_txn(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    i_dev_addr = dev;
    i_reg_addr = ra;
    i_wr_data  = wd;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    i_completed = 1'b1;
    @(negedge clk);
    i_completed = 1'b0;
    check("rst_pre_data_reg", o_data, ra);
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("rst_mid_op", o_op, OP_STOP);
    check("rst_mid_data", o_data, 8'h00);
    check("rst_mid_busy", o_busy, 1'b0);
    for (int k = 0; k < 12; k++) begin
      check("rst_no_done", o_done, 1'b0);
      check("rst_stays_idle", o_busy, 1'b0);
      if (k == 3) i_completed = 1'b1;
      else i_completed = 1'b0;
      @(negedge clk);
    end
    i_completed = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_completed = 1'b0;
    i_dev_addr  = 7'h00;
    i_reg_addr  = 8'h00;
    i_wr_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_op", o_op, OP_STOP);
    check("reset_data", o_data, 8'h00);
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_done, 1'b0);
    check("reset_error", o_error, 1'b0);
    i_rst = 1'b0;
    @(negedge clk);
    i_completed = 1'b1;
    @(negedge clk);
    i_completed = 1'b0;
    check("idle_completed_ignored", o_busy, 1'b0);

    run_txn(7'h1A, 8'h0F, 8'h55, 1'b0, 1'b0);
    run_txn(7'h1A, 8'h0F, 8'h55, 1'b1, 1'b0);
    run_txn(7'h7F, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_txn(7'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    reset_mid_txn(7'h22, 8'hA5, 8'h3C);
    run_txn(7'h22, 8'hA5, 8'h3C, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      run_txn(7'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
